// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: FSM states, opcode/funct codes, ALU operand selects.
package mips_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned ALUOP_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    ADDI_EX  = 4'd8,
    ADDI_WB  = 4'd9,
    BRANCH   = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

  localparam logic [OP_W-1:0] F_ADD = 6'h20;
  localparam logic [OP_W-1:0] F_SLL = 6'h00;
  localparam logic [OP_W-1:0] F_SRL = 6'h02;

  localparam logic [SRC_W-1:0] SRCA_PC = 2'd0;
  localparam logic [SRC_W-1:0] SRCA_RS = 2'd1;
  localparam logic [SRC_W-1:0] SRCA_RT = 2'd2;

  localparam logic [SRC_W-1:0] SRCB_REG    = 2'd0;
  localparam logic [SRC_W-1:0] SRCB_FOUR   = 2'd1;
  localparam logic [SRC_W-1:0] SRCB_IMM    = 2'd2;
  localparam logic [SRC_W-1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd2;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, stalling on the memory ready handshake.
module multicycle_control
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_en,
  output logic               pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic [SRC_W-1:0]   alu_src_a,
  output logic [SRC_W-1:0]   alu_src_b,
  output logic               alu_force_add,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  logic   is_shift;

  assign is_shift = (funct == F_SLL) || (funct == F_SRL);
  assign state    = STATE_W'(state_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control decode; enables are gated off while reset is high.
  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    alu_force_add = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read      = 1'b1;
        alu_src_b     = SRCB_FOUR;
        alu_force_add = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b     = SRCB_IMM_SH;
        alu_force_add = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_ADDI:      state_d = ADDI_EX;
          OP_BEQ:       state_d = BRANCH;
          OP_RTYPE:     state_d = (funct == F_ADD || is_shift) ? RTYPE_EX : HALT;
          default:      state_d = HALT;
        endcase
      end
      MEMADR: begin
        alu_src_a     = SRCA_RS;
        alu_src_b     = SRCB_IMM;
        alu_force_add = 1'b1;
        state_d       = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      RTYPE_EX: begin
        alu_src_a = is_shift ? SRCA_RT : SRCA_RS;
        state_d   = RTYPE_WB;
      end
      RTYPE_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDI_EX: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a  = SRCA_RS;
        pc_src     = 1'b1;
        pc_en      = zero;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      HALT: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = HALT;
      end
    endcase

    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: expected per-cycle control
// vectors are queued as each cycle is driven and checked at the falling edge.
module tb_multicycle_control;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       force_add;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_en, pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_force_add, instr_done, illegal;
  logic [1:0] alu_src_a, alu_src_b;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  ctl_t  sb_q[$];
  string tag_q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_force_add(alu_force_add),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Control vector a state must show, per the state table.
  function automatic ctl_t expect_of(input state_t st, input logic rdy, input logic zr,
                                     input logic rst);
    ctl_t e;
    logic shift;
    shift = (funct == 6'h00) || (funct == 6'h02);
    e = '0;
    e.st = 4'(st);
    case (st)
      FETCH:    begin e.mem_read = 1'b1; e.src_b = 2'd1; e.force_add = 1'b1;
                      e.ir_write = rdy; e.pc_en = rdy; end
      DECODE:   begin e.src_b = 2'd3; e.force_add = 1'b1; end
      MEMADR:   begin e.src_a = 2'd1; e.src_b = 2'd2; e.force_add = 1'b1; end
      MEMRD:    begin e.mem_read = 1'b1; e.iord = 1'b1; end
      MEMWB:    begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1; end
      MEMWR:    begin e.mem_write = 1'b1; e.iord = 1'b1; e.instr_done = rdy; end
      RTYPE_EX: begin e.src_a = shift ? 2'd2 : 2'd1; end
      RTYPE_WB: begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1; end
      ADDI_EX:  begin e.src_a = 2'd1; e.src_b = 2'd2; end
      ADDI_WB:  begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
      BRANCH:   begin e.src_a = 2'd1; e.pc_src = 1'b1; e.pc_en = zr; e.instr_done = 1'b1; end
      HALT:     begin e.illegal = 1'b1; end
      default:  begin end
    endcase
    if (rst) begin
      e.mem_read = 1'b0; e.mem_write = 1'b0; e.ir_write = 1'b0;
      e.pc_en = 1'b0; e.reg_write = 1'b0; e.instr_done = 1'b0;
    end
    return e;
  endfunction

  // One clock cycle: drive inputs, queue the expectation, check mid-cycle.
  task automatic step(input state_t st, input logic rdy, input logic zr, input logic rst,
                      input string tag);
    ctl_t  exp_v, obs_v;
    string t;
    reset     = rst;
    mem_ready = rdy;
    zero      = zr;
    sb_q.push_back(expect_of(st, rdy, zr, rst));
    tag_q.push_back(tag);
    @(negedge clk);
    exp_v = sb_q.pop_front();
    t     = tag_q.pop_front();
    obs_v = {state, mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_force_add, instr_done, illegal};
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs_v, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(FETCH, 1'b1, 1'b0, 1'b1, "reset_hold1");
    step(FETCH, 1'b1, 1'b0, 1'b1, "reset_hold2");

    // add
    step(FETCH,    1'b1, 1'b0, 1'b0, "add_fetch");
    step(DECODE,   1'b1, 1'b0, 1'b0, "add_decode");
    step(RTYPE_EX, 1'b1, 1'b0, 1'b0, "add_ex");
    step(RTYPE_WB, 1'b1, 1'b0, 1'b0, "add_wb");

    // sll: shift operand comes from rt
    set_instr(6'h00, 6'h00);
    step(FETCH,    1'b1, 1'b0, 1'b0, "sll_fetch");
    step(DECODE,   1'b0, 1'b0, 1'b0, "sll_decode");
    step(RTYPE_EX, 1'b1, 1'b0, 1'b0, "sll_ex");
    step(RTYPE_WB, 1'b1, 1'b0, 1'b0, "sll_wb");

    // addi
    set_instr(6'h08, 6'h15);
    step(FETCH,   1'b1, 1'b0, 1'b0, "addi_fetch");
    step(DECODE,  1'b1, 1'b0, 1'b0, "addi_decode");
    step(ADDI_EX, 1'b0, 1'b0, 1'b0, "addi_ex");
    step(ADDI_WB, 1'b1, 1'b0, 1'b0, "addi_wb");

    // lw with two stall cycles in MEMRD: 7 cycles total
    set_instr(6'h23, 6'h00);
    step(FETCH,  1'b1, 1'b0, 1'b0, "lw_fetch");
    step(DECODE, 1'b1, 1'b0, 1'b0, "lw_decode");
    step(MEMADR, 1'b1, 1'b0, 1'b0, "lw_memadr");
    step(MEMRD,  1'b0, 1'b0, 1'b0, "lw_memrd_stall1");
    step(MEMRD,  1'b0, 1'b0, 1'b0, "lw_memrd_stall2");
    step(MEMRD,  1'b1, 1'b0, 1'b0, "lw_memrd_done");
    step(MEMWB,  1'b0, 1'b0, 1'b0, "lw_memwb");

    // sw with a fetch stall
    set_instr(6'h2B, 6'h00);
    step(FETCH,  1'b0, 1'b0, 1'b0, "sw_fetch_stall");
    step(FETCH,  1'b1, 1'b0, 1'b0, "sw_fetch");
    step(DECODE, 1'b1, 1'b0, 1'b0, "sw_decode");
    step(MEMADR, 1'b1, 1'b0, 1'b0, "sw_memadr");
    step(MEMWR,  1'b1, 1'b0, 1'b0, "sw_memwr");

    // beq taken then not taken
    set_instr(6'h04, 6'h00);
    step(FETCH,  1'b1, 1'b1, 1'b0, "beq_t_fetch");
    step(DECODE, 1'b1, 1'b1, 1'b0, "beq_t_decode");
    step(BRANCH, 1'b0, 1'b1, 1'b0, "beq_t_branch");
    step(FETCH,  1'b1, 1'b0, 1'b0, "beq_n_fetch");
    step(DECODE, 1'b1, 1'b0, 1'b0, "beq_n_decode");
    step(BRANCH, 1'b1, 1'b0, 1'b0, "beq_n_branch");

    // sw interrupted by reset during a MEMWR stall
    set_instr(6'h2B, 6'h00);
    step(FETCH,  1'b1, 1'b0, 1'b0, "swr_fetch");
    step(DECODE, 1'b1, 1'b0, 1'b0, "swr_decode");
    step(MEMADR, 1'b1, 1'b0, 1'b0, "swr_memadr");
    step(MEMWR,  1'b0, 1'b0, 1'b0, "swr_memwr_stall");
    step(MEMWR,  1'b1, 1'b0, 1'b1, "swr_memwr_reset");
    step(FETCH,  1'b0, 1'b0, 1'b0, "swr_refetch");

    // illegal opcode: sticky HALT until reset
    set_instr(6'h3F, 6'h00);
    step(FETCH,  1'b1, 1'b0, 1'b0, "ill_op_fetch");
    step(DECODE, 1'b1, 1'b0, 1'b0, "ill_op_decode");
    for (int i = 0; i < 10; i++)
      step(HALT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "ill_op_halt");
    step(HALT,   1'b1, 1'b0, 1'b1, "ill_op_reset");

    // unsupported R-type funct
    set_instr(6'h00, 6'h08);
    step(FETCH,  1'b1, 1'b0, 1'b0, "ill_fn_fetch");
    step(DECODE, 1'b1, 1'b0, 1'b0, "ill_fn_decode");
    for (int i = 0; i < 3; i++)
      step(HALT, 1'b1, 1'b1, 1'b0, "ill_fn_halt");
    step(HALT,   1'b1, 1'b0, 1'b1, "ill_fn_reset");

    // srl after recovery
    set_instr(6'h00, 6'h02);
    step(FETCH,    1'b1, 1'b0, 1'b0, "srl_fetch");
    step(DECODE,   1'b1, 1'b0, 1'b0, "srl_decode");
    step(RTYPE_EX, 1'b1, 1'b0, 1'b0, "srl_ex");
    step(RTYPE_WB, 1'b1, 1'b0, 1'b0, "srl_wb");
    step(FETCH,    1'b1, 1'b0, 1'b0, "srl_next_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
